// File: rtl/mac_accumulator_pkg.sv
// Shared types and default widths for the product accumulator.
// Saturating overflow is selected with the MAC_ACCUMULATOR_SAT_EN macro.
package mac_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_N     = 4;
    localparam int DEF_ACC_W = 2 * DEF_N + 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/acc_add.sv
// ACC_W-bit accumulator adder with carry-out.
// MAC_ACCUMULATOR_SAT_EN defined: clamp to all-ones on carry; otherwise wrap.
module acc_add
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o  = full_sum[ACC_W];

`ifdef MAC_ACCUMULATOR_SAT_EN
    // Once clamped, any later add either carries again or adds zero, so it stays clamped.
    assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Packet accumulator for multiplier products: sums beats until in_last, then holds the result.
// Overflow handling depends on MAC_ACCUMULATOR_SAT_EN (see acc_add).
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = 2 * N + 4,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    assign accept = in_valid && in_ready;
    assign in_ext = ACC_W'(in_data);

    acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .a_i     (acc_q),
        .b_i     (in_ext),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // HOLD blocks input, so the next packet's first beat lands one cycle after the handshake.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_data  = acc_q;
        out_count = cnt_q;
        out_ovf   = ovf_q;
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            if (state_q == IDLE) begin
                // First beat of a packet replaces whatever the last packet left behind.
                acc_d = in_ext;
                cnt_d = CNT_W'(1);
                ovf_d = 1'b0;
            end else begin
                acc_d = add_sum;
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                ovf_d = ovf_q | add_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter N, default 4: operand width of the upstream multiplier; the product input is 2*N bits.
REQ-002 Parameter ACC_W, default 2*N+4: accumulator width; must satisfy ACC_W >= 2*N.
REQ-003 Parameter CNT_W, default 8: beat-counter width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: product beat valid.
REQ-007 Port in_ready, output, 1: block can accept a beat.
REQ-008 Port in_data, input, 2*N: unsigned product p from the multiplier stage.
REQ-009 Port in_last, input, 1: final beat of the packet; qualified by in_valid.
REQ-010 Port out_valid, output, 1: accumulated result available.
REQ-011 Port out_ready, input, 1: downstream accepts the result.
REQ-012 Port out_data, output, ACC_W: accumulated sum.
REQ-013 Port out_count, output, CNT_W: number of beats accepted in the packet.
REQ-014 Port out_ovf, output, 1: at least one accumulation in the packet exceeded ACC_W bits.

Function
REQ-015 The block SHALL use three states: IDLE, ACCUM and HOLD.
REQ-016 A beat SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-018 A beat accepted in IDLE SHALL load the accumulator with zero-extended in_data, set the count to 1 and clear the overflow flag; it SHALL NOT add to any previous value.
REQ-019 A beat accepted in ACCUM SHALL add zero-extended in_data to the accumulator and increment the count; the count SHALL saturate at all-ones.
REQ-020 State transitions:
- IDLE -> ACCUM on an accepted beat with in_last = 0.
- IDLE or ACCUM -> HOLD on an accepted beat with in_last = 1.
- HOLD -> IDLE on out_valid && out_ready.
- All other cases hold the current state.
REQ-021 out_valid SHALL be 1 exactly while in HOLD, i.e. it asserts the cycle after the last beat is accepted; this is one cycle of latency.
REQ-022 out_data, out_count and out_ovf SHALL remain stable throughout HOLD.
REQ-023 There SHALL be no same-cycle input bypass in HOLD; the earliest next beat is accepted the cycle after the handshake, giving a one-cycle bubble.
REQ-024 in_data = 0 beats SHALL be counted normally.
REQ-025 Overflow is a carry out of bit ACC_W-1 on any add; it SHALL set out_ovf, which stays set until the next packet starts.

Reset
REQ-026 When rst_n = 0, the state SHALL be IDLE and the accumulator, count, overflow flag, out_valid, out_data, out_count and out_ovf SHALL all be 0; in_ready SHALL be 1.
REQ-027 Reset asserted mid-packet or during HOLD SHALL discard the partial or pending result without emitting it.

Configuration
REQ-028 The macro MAC_ACCUMULATOR_SAT_EN SHALL select the overflow behaviour:
- Defined: on overflow the accumulator clamps to all-ones and stays there for the rest of the packet; out_ovf is still set.
- Undefined: the accumulator wraps modulo 2^ACC_W.

Structure
REQ-029 Package mac_accumulator_pkg SHALL hold the state enum type (IDLE/ACCUM/HOLD) and the default width constants.
REQ-030 Sub-module acc_add SHALL implement the ACC_W-bit adder, producing carry-out and the clamped or wrapped sum according to MAC_ACCUMULATOR_SAT_EN; the FSM, counters and handshake remain in mac_accumulator.

Verification (N=4, ACC_W=12, CNT_W=8)
REQ-031 Three beats of 225 with last on beat 3 and out_ready = 1 -> out_valid one cycle later with out_data = 675, out_count = 3, out_ovf = 0.
REQ-032 Single beat of 42 with in_last = 1 -> out_data = 42, out_count = 1; a following beat of 7 yields out_data = 7, not 49.
REQ-033 out_ready held at 0 for 5 cycles in HOLD -> in_ready = 0 and outputs stable for all 5 cycles; the result is released on the handshake and state returns to IDLE the next cycle.
REQ-034 Nineteen beats of 225 (total 4275) -> without the macro out_data = 179 and out_ovf = 1; with MAC_ACCUMULATOR_SAT_EN out_data = 4095 and out_ovf = 1.
REQ-035 rst_n pulsed low after 2 of 4 beats -> no out_valid; a new packet of 10 then 20 (last) gives out_data = 30, out_count = 2.
REQ-036 in_valid toggling 1,0,1,0,1 (last on the third valid beat, data 5) -> out_data = 15, out_count = 3; idle cycles do not change the accumulator.
